// File: rtl/tpu_pkg.sv
// tpu_pkg: shared constants and sequencer state encoding for the tpu front end
package tpu_pkg;

    localparam int TPU_IW = 16;
    localparam logic [TPU_IW-1:0] TPU_NOP = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tpu_prog_ram.sv
// tpu_prog_ram: program store with synchronous write and combinational read
module tpu_prog_ram #(
    parameter int IW    = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];

    // write port; the array has no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tpu_instr_sequencer.sv
// tpu_instr_sequencer: program buffer that replays stored words into the tpu with a NOP gap
module tpu_instr_sequencer
    import tpu_pkg::*;
#(
    parameter int IW    = TPU_IW,
    parameter int DEPTH = 16,
    parameter int GAP_W = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [IW-1:0]    load_data,
    output logic             load_ready,
    input  logic             clear,
    input  logic             run,
    input  logic             abort,
    input  logic [GAP_W-1:0] gap,
    output logic [IW-1:0]    instruction,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             ovf_err
);

    state_e            state, nxt;
    logic [CW-1:0]     rptr;
    logic [GAP_W-1:0]  gap_q, gcnt;
    logic [IW-1:0]     rd_data;
    logic [AW-1:0]     raddr;
    logic              full, idle, clr, we;

    assign idle       = state == IDLE;
    assign full       = count == CW'(DEPTH);
    assign clr        = idle && clear;
    assign load_ready = idle && !full;
    assign we         = load_valid && load_ready && !clear;
    assign busy       = state == ISSUE || state == GAP;
    assign done       = state == DONE;
    // rptr names the next word to fetch; a fresh run always starts at word 0
    assign raddr      = idle ? '0 : rptr[AW-1:0];

    tpu_prog_ram #(.IW(IW), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (count[AW-1:0]),
        .wdata (load_data),
        .raddr (raddr),
        .rdata (rd_data)
    );

    // next state; abort overrides everything, including a simultaneous run
    always_comb begin
        nxt = state;
        if (abort) nxt = IDLE;
        else begin
            unique case (state)
                IDLE:  nxt = (run && count != '0) ? ISSUE : IDLE;
                ISSUE: nxt = (rptr == count) ? DONE : (gap_q == '0) ? ISSUE : GAP;
                GAP:   nxt = (gcnt == GAP_W'(1)) ? ISSUE : GAP;
                DONE:  nxt = IDLE;
            endcase
        end
    end

    // state, issue register and pointers; the word is fetched on entry to ISSUE so it shows the cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instruction <= TPU_NOP;
            rptr        <= '0;
            gap_q       <= '0;
            gcnt        <= '0;
        end else begin
            state       <= nxt;
            instruction <= (nxt == ISSUE) ? rd_data : TPU_NOP;
            if (nxt == ISSUE) rptr <= idle ? CW'(1) : rptr + CW'(1);
            if (idle && nxt == ISSUE) gap_q <= gap;
            gcnt        <= (state == GAP) ? gcnt - GAP_W'(1) : gap_q;
        end
    end

    // buffer occupancy and sticky overflow flag; clear beats a same-cycle load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            count   <= clr ? '0 : we ? count + CW'(1) : count;
            ovf_err <= clr ? 1'b0 : (load_valid && idle && full) ? 1'b1 : ovf_err;
        end
    end

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// tb_tpu_instr_sequencer: directed stimulus with a cycle-stamped scoreboard for the issue stream
module tb_tpu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  gap = '0;
    logic [15:0] instruction;
    logic        busy;
    logic        done;
    logic [4:0]  count;
    logic        ovf_err;

    typedef struct {
        int          cyc;
        logic [15:0] ins;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic [15:0] prog [3] = '{16'hA1B2, 16'h0C03, 16'h7F00};

    tpu_instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .clear       (clear),
        .run         (run),
        .abort       (abort),
        .gap         (gap),
        .instruction (instruction),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a === x) passes++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", n, cyc, a, x);
    endtask

    task automatic push(input int t, input logic [15:0] w, input logic b, input logic d);
        sb.push_back('{cyc: t, ins: w, busy: b, done: d});
    endtask

    // monitor: every cycle either matches a stamped expectation or must be quiet
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missed_slot", 32'(sb[0].cyc), 32'(cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("instruction", 32'(instruction), 32'(e.ins));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("done", 32'(done), 32'(e.done));
            end else begin
                chk("quiet", {15'd0, done, instruction}, 32'd0);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic load(input logic [15:0] w);
        load_valid = 1'b1;
        load_data  = w;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 3; i++) load(prog[i]);
    endtask

    task automatic run_prog(input int g);
        int t;
        t = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            push(t, prog[i], 1'b1, 1'b0);
            t++;
            if (i < 2) for (int j = 0; j < g; j++) begin
                push(t, 16'h0000, 1'b1, 1'b0);
                t++;
            end
        end
        push(t, 16'h0000, 1'b0, 1'b1);
        push(t + 1, 16'h0000, 1'b0, 1'b0);
        gap = 4'(g);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        gap = 4'hF;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_instruction", 32'(instruction), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        load_prog();
        chk("count3", 32'(count), 32'd3);
        run_prog(0);
        run_prog(2);
        pulse_clear();
        chk("clear_count", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++) load(16'(i * 16'h0101 + 16'h0001));
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(load_ready), 32'd0);
        chk("full_no_ovf", 32'(ovf_err), 32'd0);
        load(16'hDEAD);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        pulse_clear();
        chk("clr2_count", 32'(count), 32'd0);
        chk("clr2_ovf", 32'(ovf_err), 32'd0);
        t = cyc + 1;
        for (int i = 0; i < 3; i++) push(t + i, 16'h0000, 1'b0, 1'b0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        drain();
        load_prog();
        t = cyc + 1;
        push(t, 16'hA1B2, 1'b1, 1'b0);
        push(t + 1, 16'h0000, 1'b1, 1'b0);
        push(t + 2, 16'h0000, 1'b1, 1'b0);
        for (int i = 3; i < 6; i++) push(t + i, 16'h0000, 1'b0, 1'b0);
        gap = 4'd3;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain();
        run_prog(0);
        t = cyc + 1;
        push(t, 16'hA1B2, 1'b1, 1'b0);
        gap = 4'd0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_instruction", 32'(instruction), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(load_ready), 32'd1);
        chk("post_rst_instruction", 32'(instruction), 32'd0);
        chk("post_rst_sb", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
